// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame controller.
package uart_tx_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Handshake bundle between the frame controller, its data source and the serializer.
interface uart_tx_fsm_if
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  ser_data;
    logic                  ser_done;
    logic                  ser_en;
    logic                  TX_OUT;
    logic                  Busy;
    logic                  ser_err;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_data, ser_done,
        input  ser_en, TX_OUT, Busy, ser_err
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_data, ser_done,
        output ser_en, TX_OUT, Busy, ser_err
    );

endinterface

// File: rtl/uart_tx_fsm_parity_calc.sv
// Parity of the parallel word: even parity when par_typ=0, odd when 1.
module parity_calc #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: start, serialized data (LSB first), optional parity, stop.
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned CNT_W      = 3
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_fsm_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               par_bit_q, par_bit_d;
    logic               par_en_q,  par_en_d;
    logic               ser_err_q, ser_err_d;
    logic               par_bit_new;

    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (bus.P_DATA),
        .par_typ (bus.PAR_TYP),
        .par_bit (par_bit_new)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            ser_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            ser_err_q <= ser_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        ser_err_d = ser_err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.DATA_VALID) begin
                    par_bit_d = par_bit_new;
                    par_en_d  = bus.PAR_EN;
                    state_d   = START;
                end
            end
            START: begin
                bit_cnt_d = '0;
                state_d   = DATA;
            end
            DATA: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    // A missing ser_done is flagged but the frame still closes on time.
                    if (!bus.ser_done) begin
                        ser_err_d = 1'b1;
                    end
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                if (bus.DATA_VALID) begin
                    par_bit_d = par_bit_new;
                    par_en_d  = bus.PAR_EN;
                    state_d   = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.TX_OUT = 1'b1;
        bus.Busy   = 1'b1;
        bus.ser_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.Busy = 1'b0;
            end
            START: begin
                bus.TX_OUT = 1'b0;
                bus.ser_en = 1'b1;
            end
            DATA: begin
                bus.TX_OUT = bus.ser_data;
                bus.ser_en = (bit_cnt_q != LAST_BIT);
            end
            PARITY: begin
                bus.TX_OUT = par_bit_q;
            end
            STOP: begin
                bus.TX_OUT = 1'b1;
            end
            default: begin
                bus.Busy = 1'b0;
            end
        endcase
    end

    assign bus.ser_err = ser_err_q;

endmodule
